// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
// SEG_ADDR_W     : width of the decode ROM address
// NIB_W          : width of one hex digit
// SEG_ADDR_BLANK : ROM address of the all-off glyph
// scan_state_t   : BLANK until the first word is committed, SCAN afterwards
package seg_pkg;

  localparam int SEG_ADDR_W = 5;
  localparam int NIB_W      = 4;
  localparam logic [SEG_ADDR_W-1:0] SEG_ADDR_BLANK = 5'd16;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/tick_gen.sv
// Digit-slot prescaler: counts 0..DIV-1 and wraps.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the counter
//   tick  : high during the last cycle of every slot (cnt == DIV-1)
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed driver for a common-anode 7-segment display.
// A word accepted over valid/ready is held in a pending register and moved
// to the display register only at a frame boundary, so a frame never shows
// a mix of two words.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : new word offered
//   in_ready   : pending register empty (low during reset)
//   in_data    : DIGITS hex nibbles, [3:0] is digit 0 (rightmost)
//   in_dp      : decimal point per digit, 1 = lit
//   addr       : decode ROM address, 16 = blank
//   an_n       : one-cold digit select
//   dp_n       : active-low decimal point
//   frame_done : one-cycle pulse after the last slot of each frame
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int LZB_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIB_W*DIGITS-1:0] in_data,
  input  logic [DIGITS-1:0]       in_dp,
  output logic [SEG_ADDR_W-1:0]   addr,
  output logic [DIGITS-1:0]       an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W = NIB_W * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic                  tick;
  logic                  frame_bound;
  logic                  xfer;
  logic                  commit;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nx;
  logic                  pending_full;
  logic [WORD_W-1:0]     pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic [WORD_W-1:0]     disp_data;
  logic [DIGITS-1:0]     disp_dp;
  logic [WORD_W-1:0]     disp_nx;
  logic [DIGITS-1:0]     dp_nx;
  logic [DIGITS-1:0]     upper_zero;
  logic [NIB_W-1:0]      nib;
  logic                  blank_digit;
  scan_state_t           state;
  scan_state_t           state_nx;
  logic [SEG_ADDR_W-1:0] addr_nx;
  logic [DIGITS-1:0]     an_nx;
  logic                  dp_n_nx;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign frame_bound = tick && (idx == IDX_LAST);
  assign in_ready    = rst_n && !pending_full;
  assign xfer        = in_valid && in_ready;
  assign commit      = frame_bound && pending_full;
  assign idx_nx      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

  // The output registers load on the commit edge, so they must see the
  // word that becomes visible on that edge rather than the old one.
  assign disp_nx = commit ? pend_data : disp_data;
  assign dp_nx   = commit ? pend_dp   : disp_dp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx_nx;
    end
  end

  // xfer needs an empty pending register and commit needs a full one, so
  // both never fire on the same edge; a word arriving exactly on a boundary
  // simply waits one frame in pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      disp_data    <= '0;
      disp_dp      <= '0;
    end else begin
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (xfer) begin
        pend_data    <= in_data;
        pend_dp      <= in_dp;
        pending_full <= 1'b1;
      end else if (commit) begin
        pending_full <= 1'b0;
      end
    end
  end

  // upper_zero[i] is set when digit i and every digit to its left are zero.
  always_comb begin : lzb_scan
    logic zero_run;
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp_nx[i*NIB_W +: NIB_W] != '0) begin
        zero_run = 1'b0;
      end
      upper_zero[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    an_nx       = an_n;
    dp_n_nx     = dp_n;
    nib         = disp_nx[idx_nx*NIB_W +: NIB_W];
    blank_digit = (LZB_EN != 0) && (idx_nx != '0) && upper_zero[idx_nx] && !dp_nx[idx_nx];

    if (commit) begin
      state_nx = SCAN;
    end

    if (tick) begin
      if (state_nx == SCAN) begin
        an_nx   = ~(DIGITS'(1) << idx_nx);
        addr_nx = blank_digit ? SEG_ADDR_BLANK : {1'b0, nib};
        dp_n_nx = ~dp_nx[idx_nx];
      end else begin
        an_nx   = '1;
        addr_nx = SEG_ADDR_BLANK;
        dp_n_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= SEG_ADDR_BLANK;
      an_n       <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      addr       <= addr_nx;
      an_n       <= an_nx;
      dp_n       <= dp_n_nx;
      frame_done <= frame_bound;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with DIGITS=4, DIV=4 (16-cycle frames).
// Edges are numbered from reset release; edge k is a frame boundary when
// k is a multiple of 16, and the output after edge k shows digit (k/4)%4.
// Each accepted word is queued with the frame number it must appear in.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_dp = 4'h0;
  logic [4:0]  addr;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          frame;
    logic [15:0] data;
    logic [3:0]  dp;
  } word_t;

  word_t       sb[$];
  int          k = 0;
  logic        xfer_next = 1'b0;
  logic [15:0] xfer_data = 16'h0;
  logic [3:0]  xfer_dp = 4'h0;
  logic        cur_valid = 1'b0;
  logic [15:0] cur_data = 16'h0;
  logic [3:0]  cur_dp = 4'h0;

  seg_scan_ctrl #(
    .DIGITS(4),
    .DIV   (4),
    .LZB_EN(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dp     (in_dp),
    .addr      (addr),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {addr, an_n, dp_n} for digit i of a displayed word.
  function automatic logic [9:0] exp_digit(input logic [15:0] d, input logic [3:0] p, input int i);
    logic       lead;
    logic [4:0] a;
    logic [3:0] an;
    lead = 1'b1;
    for (int j = i; j < 4; j++) begin
      if (d[j*4 +: 4] != 4'h0) lead = 1'b0;
    end
    a = (i > 0 && lead && !p[i]) ? 5'd16 : {1'b0, d[i*4 +: 4]};
    an = 4'hF;
    an[i] = 1'b0;
    return {a, an, ~p[i]};
  endfunction

  // Handshake sampled mid-cycle, once inputs are settled; the bench's own
  // view of readiness is "no word waiting for its frame".
  always @(negedge clk) begin
    #1;
    xfer_next = in_valid && rst_n && (sb.size() == 0);
    xfer_data = in_data;
    xfer_dp   = in_dp;
  end

  // Edge bookkeeping, then a full output check a little after every edge.
  always @(posedge clk) begin
    logic [9:0] exp_o;
    logic       exp_fd;
    logic       exp_rdy;
    word_t      w;
    if (!rst_n) begin
      k = 0;
      sb.delete();
      cur_valid = 1'b0;
    end else begin
      k = k + 1;
      if (xfer_next) sb.push_back('{k / 16 + 1, xfer_data, xfer_dp});
      while (sb.size() > 0 && sb[0].frame <= k / 16) begin
        w = sb.pop_front();
        cur_valid = 1'b1;
        cur_data  = w.data;
        cur_dp    = w.dp;
      end
    end
    exp_o   = cur_valid ? exp_digit(cur_data, cur_dp, (k / 4) % 4) : {5'd16, 4'hF, 1'b1};
    exp_fd  = rst_n && (k > 0) && (k % 16 == 0);
    exp_rdy = rst_n && (sb.size() == 0);
    #3;
    checkOutput("addr", 32'(addr), 32'(exp_o[9:5]));
    checkOutput("an_n", 32'(an_n), 32'(exp_o[4:1]));
    checkOutput("dp_n", 32'(dp_n), 32'(exp_o[0]));
    checkOutput("frame_done", 32'(frame_done), 32'(exp_fd));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one word and hold it until accepted; optionally line the offer up
  // so the transfer lands on a frame-boundary edge.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input bit at_boundary);
    int n;
    @(negedge clk);
    n = 0;
    if (at_boundary) begin
      while (((k + 1) % 16) != 0 && n < 64) begin
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_dp    = p;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_dp    = 4'hF;
  endtask

  task automatic resetDut(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitCycles(40);

    $display("[TB] basic scan");
    applyStimulus(16'h1A3F, 4'b0100, 1'b0);
    waitCycles(40);

    $display("[TB] leading zeros");
    applyStimulus(16'h0007, 4'b0000, 1'b0);
    waitCycles(40);
    applyStimulus(16'h0000, 4'b0000, 1'b0);
    waitCycles(40);
    applyStimulus(16'h0050, 4'b1000, 1'b0);
    waitCycles(40);

    $display("[TB] backpressure");
    applyStimulus(16'h2468, 4'b0001, 1'b0);
    applyStimulus(16'h9BDF, 4'b0010, 1'b0);
    waitCycles(50);

    $display("[TB] transfer on boundary");
    applyStimulus(16'hC0DE, 4'b1000, 1'b1);
    waitCycles(40);

    $display("[TB] mid-frame reset");
    applyStimulus(16'hBEEF, 4'b0000, 1'b0);
    n = 0;
    while (((k / 4) % 4) != 2 && n < 64) begin
      @(negedge clk);
      n++;
    end
    resetDut(1);
    waitCycles(40);
    applyStimulus(16'h4321, 4'b0011, 1'b0);
    waitCycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
